weight_control_unit: RTL

Producer side of the weight handshake consumed by compute_control_unit. Streams MUL_SIZE x MUL_SIZE weight tiles from weight memory into the systolic array's shadow weight registers, and promotes shadow to active on a swap pulse. Drives compute_weights_rdy / compute_weights_buffered and consumes next_weight_tile. Tile order is y-inner, x-outer, matching the compute side's consumption order.

---
 rtl/tpu_package.sv | 7 +
 rtl/weight_control_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/tpu_package.sv
// tpu_package: shared TPU array constants and control-state types
package tpu_package;
  localparam int MUL_SIZE = 32;
  localparam int TILE_SHIFT = 5;
  localparam int WEIGHT_ADDR_W = 12;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} weight_ctrl_state_t;
endpackage

// File: rtl/weight_control_unit.sv
// weight_control_unit: streams weight tiles into shadow registers and hands them to compute
module weight_control_unit
  import tpu_package::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instruction_i,
  input  logic [8:0]               H_DIM_i,
  input  logic [8:0]               W_DIM_i,
  input  logic [WEIGHT_ADDR_W-1:0] weight_base_addr_i,
  input  logic                     next_weight_tile_i,
  output logic                     weight_mem_rd_en_o,
  output logic [WEIGHT_ADDR_W-1:0] weight_mem_addr_rd_o,
  output logic                     load_weights_o,
  output logic [TILE_SHIFT-1:0]    weight_row_idx_o,
  output logic                     swap_weights_o,
  output logic                     compute_weights_rdy_o,
  output logic                     compute_weights_buffered_o,
  output logic                     done_o
);
  weight_ctrl_state_t       state_q;
  logic [WEIGHT_ADDR_W-1:0] addr_q;
  logic [8:0]               total_q, fetch_q, used_q, tiles_x, tiles_y;
  logic [TILE_SHIFT:0]      row_q;
  logic [TILE_SHIFT-1:0]    rd_row_q, idx_q;
  logic                     rd_en_q, load_q, active_q, shadow_q, done_q, swap, release_tile;
  assign tiles_x = (W_DIM_i >> TILE_SHIFT) + 9'd1;
  assign tiles_y = (H_DIM_i >> TILE_SHIFT) + 9'd1;
  // swap is combinational so compute sees it in the same cycle it releases a tile
  assign swap = (state_q == HOLD) && (!active_q || next_weight_tile_i);
  assign release_tile = (state_q != IDLE) && active_q && next_weight_tile_i;
  // tiles are contiguous in memory, so the read address simply keeps counting
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      total_q  <= '0;
      fetch_q  <= '0;
      used_q   <= '0;
      row_q    <= '0;
      rd_row_q <= '0;
      idx_q    <= '0;
      rd_en_q  <= 1'b0;
      load_q   <= 1'b0;
      active_q <= 1'b0;
      shadow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      load_q  <= rd_en_q;
      idx_q   <= rd_row_q;
      done_q  <= 1'b0;
      if (release_tile) begin
        used_q <= used_q + 9'd1;
        if (!swap) active_q <= 1'b0;
      end
      if (swap) begin
        active_q <= 1'b1;
        shadow_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (instruction_i) begin
          state_q  <= FETCH;
          total_q  <= tiles_x * tiles_y;
          fetch_q  <= '0;
          used_q   <= '0;
          rd_en_q  <= 1'b1;
          addr_q   <= weight_base_addr_i;
          rd_row_q <= '0;
          row_q    <= (TILE_SHIFT+1)'(1);
        end
        FETCH: if (row_q < (TILE_SHIFT+1)'(MUL_SIZE)) begin
          rd_en_q  <= 1'b1;
          addr_q   <= addr_q + WEIGHT_ADDR_W'(1);
          rd_row_q <= row_q[TILE_SHIFT-1:0];
          row_q    <= row_q + (TILE_SHIFT+1)'(1);
        end else if (!rd_en_q) begin
          state_q  <= HOLD;
          shadow_q <= 1'b1;
          fetch_q  <= fetch_q + 9'd1;
        end
        HOLD: if (swap) begin
          if (fetch_q < total_q) begin
            state_q  <= FETCH;
            rd_en_q  <= 1'b1;
            addr_q   <= addr_q + WEIGHT_ADDR_W'(1);
            rd_row_q <= '0;
            row_q    <= (TILE_SHIFT+1)'(1);
          end else state_q <= DRAIN;
        end
        default: ;
      endcase
      if (release_tile && used_q == total_q - 9'd1) begin
        state_q  <= IDLE;
        done_q   <= 1'b1;
        active_q <= 1'b0;
      end
    end
  end
  assign weight_mem_rd_en_o         = rd_en_q;
  assign weight_mem_addr_rd_o       = addr_q;
  assign load_weights_o             = load_q;
  assign weight_row_idx_o           = idx_q;
  assign swap_weights_o             = swap;
  assign compute_weights_rdy_o      = active_q;
  assign compute_weights_buffered_o = shadow_q;
  assign done_o                     = done_q;
endmodule
